// File: rtl/ascon_pack.sv
// Shared types, FSM encoding and round-constant helper for the ASCON permutation.
package ascon_pack;

    // S_0 occupies the most significant word of the packed 320-bit state.
    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] s4;
    } type_state;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_fsm_t;

    localparam logic [3:0] ROUND_MAX = 4'd11;

    // c_i = {(F - i), i}: 0xF0 for i=0 down to 0x4B for i=11.
    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        logic [127:0] t;
        t = {x, x} >> n;
        return t[63:0];
    endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational ASCON round: constant addition, substitution layer, linear diffusion.
module permutation_round
    import ascon_pack::*;
(
    input  type_state   state_i,
    input  logic [3:0]  round_i,
    output type_state   state_o
);

    function automatic type_state couche_substitution(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        type_state   r;
        x0 = s.s0 ^ s.s4;
        x1 = s.s1;
        x2 = s.s2 ^ s.s1;
        x3 = s.s3;
        x4 = s.s4 ^ s.s3;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        // Order matters: x1 and x0 use the already-updated neighbours.
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r.s0 = x0;
        r.s1 = x1;
        r.s2 = x2;
        r.s3 = x3;
        r.s4 = x4;
        return r;
    endfunction

    function automatic type_state couche_diffusion(input type_state s);
        type_state r;
        r.s0 = s.s0 ^ rotr64(s.s0, 19) ^ rotr64(s.s0, 28);
        r.s1 = s.s1 ^ rotr64(s.s1, 61) ^ rotr64(s.s1, 39);
        r.s2 = s.s2 ^ rotr64(s.s2, 1)  ^ rotr64(s.s2, 6);
        r.s3 = s.s3 ^ rotr64(s.s3, 10) ^ rotr64(s.s3, 17);
        r.s4 = s.s4 ^ rotr64(s.s4, 7)  ^ rotr64(s.s4, 41);
        return r;
    endfunction

    type_state added_w;

    always_comb begin
        added_w          = state_i;
        added_w.s2[7:0]  = state_i.s2[7:0] ^ round_const(round_i);
    end

    assign state_o = couche_diffusion(couche_substitution(added_w));

endmodule

// File: rtl/permutation_controller.sv
// Sequences ASCON p^a / p^b one round per clock with a start/done handshake.
// Optional PERM_STALL_EN adds stall_i, which freezes the running permutation.
module permutation_controller
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        mode_i,
`ifdef PERM_STALL_EN
    input  logic        stall_i,
`endif
    input  type_state   state_i,
    output type_state   state_o,
    output logic [3:0]  round_o,
    output logic        busy_o,
    output logic        done_o
);

    // Rounds always end at index 11, so shorter permutations start later.
    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

    perm_fsm_t   fsm_q, fsm_d;
    type_state   state_q, state_d;
    logic [3:0]  round_q, round_d;
    type_state   round_next_w;
    logic        stall_w;

`ifdef PERM_STALL_EN
    assign stall_w = stall_i;
`else
    assign stall_w = 1'b0;
`endif

    permutation_round u_round (
        .state_i (state_q),
        .round_i (round_q),
        .state_o (round_next_w)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    round_d = mode_i ? START_B : START_A;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall_w) begin
                    state_d = round_next_w;
                    if (round_q == ROUND_MAX) begin
                        fsm_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = (fsm_q != ST_IDLE);
    assign done_o  = (fsm_q == ST_DONE);

endmodule

// File: doc/permutation_controller.md
Name: permutation_controller

Overview:
Sequences the ASCON permutation p^a / p^b over a 320-bit type_state register. One round per clock: constant addition, then substitution layer p_s, then linear diffusion. Start/done handshake toward the mode FSM (initialisation, associated data, plaintext, finalisation). Sits between the top-level ASCON FSM and the combinational round datapath.

Parameters:
ROUNDS_A, 12, round count for p^a (mode_i=0); legal range 1..12
ROUNDS_B, 6, round count for p^b (mode_i=1); legal range 1..12

Ports:
clock_i  in  1  system clock; all state changes on rising edge
reset_i  in  1  reset; one clock, synchronous, active-high
start_i  in  1  request a permutation; sampled only in IDLE
mode_i  in  1  0 selects ROUNDS_A, 1 selects ROUNDS_B; sampled with start_i
state_i  in  320 (type_state)  input state; captured on start acceptance
state_o  out  320 (type_state)  state register contents
round_o  out  4  current round-constant index i
busy_o  out  1  high while not IDLE
done_o  out  1  one-cycle pulse; final state valid on state_o

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset → IDLE; state register = 0; round counter = 0; done_o = 0; busy_o = 0.
- IDLE, start_i=1 (edge k):
  - state register ← state_i.
  - counter ← 12 − N, where N = ROUNDS_A or ROUNDS_B per mode_i.
  - Go to RUN.
- IDLE, start_i=0: hold. The state register keeps its last value, so state_o holds the previous result.
- RUN, each edge:
  - state register ← round(state register, counter).
  - Round constant c_i = {(4'hF − i), i[3:0]}, XORed into the low byte of S_2. i=0 → 0xF0, i=11 → 0x4B.
  - If counter == 11 → DONE; else counter + 1.
- N rounds occupy edges k+1 .. k+N.
- DONE (one cycle): done_o=1; state_o = final state. Next edge → IDLE. Counter holds 11 in DONE.
- Latency: done_o high during the cycle after edge k+N; start-to-done = N+1 cycles. Back-to-back start accepted at earliest on edge k+N+2.
- start_i while busy_o=1 (RUN or DONE) is ignored. It is not queued.
- mode_i and state_i are don't-care outside the accept edge.
- round_o = counter at all times; 0 after reset.
- Reset mid-RUN or in DONE: next edge → IDLE with all reset values. No done_o pulse for the aborted run.
- Reset and start_i on the same edge: reset wins.
- Counter width is 4 bits. It never exceeds 11, so there is no wrap.

Optional Feature:
PERM_STALL_EN
- Defined: adds port stall_i (in, 1). In RUN with stall_i=1, the state register and counter hold and no round is applied; latency stretches by one cycle per stalled cycle. stall_i is ignored in IDLE and DONE. Reset overrides stall.
- Undefined: no stall_i port; rounds run on consecutive cycles.

Decomposition:
- ascon_pack holds:
  - type_state (5 × 64-bit words, S_0 first);
  - round-constant function or table (12 entries);
  - FSM state enum;
  - ROUND_MAX = 11.
- Sub-module permutation_round: purely combinational. Inputs state and round index; output next state. It chains constant addition, couche_substitution and couche_diffusion. The controller instantiates exactly one permutation_round and owns all registers.

Test Plan:
- Reset, then idle for 5 cycles → state_o=0, round_o=0, busy_o=0, done_o=0 throughout.
- mode_i=0, start_i=1 with S_0=64'h80400c0600000000, S_1..S_4 = key/nonce test vector → round_o steps 0..11 on successive cycles. done_o pulses exactly 13 cycles after the start edge. state_o matches the golden-model p^12 output.
- mode_i=1, same state → round_o steps 6..11. done_o pulses at start+7. Result matches golden p^6. First-round constant observed = 0x96.
- start_i held high continuously → second run accepted on the first edge after DONE. Exactly one done_o pulse per run; no pulse is lost or duplicated.
- reset_i asserted at the 4th RUN cycle → next cycle IDLE, state_o=0, round_o=0, no done_o.
- With PERM_STALL_EN: stall_i high for 3 cycles mid-run, p^12 → state_o and round_o frozen during the stall. done_o at start+16. Final state is identical to the unstalled run.
